// File: rtl/controller_modulo.sv
`default_nettype none
// ============================================================================
//  Module   : controller_modulo
//  Purpose  : Control unit for the modulo datapath. After a start request it
//             loads the operands, copies Zahl1 into ergebnis and then loops
//             compare (ergebnis < Zahl2 ?) / subtract (ergebnis -= Zahl2)
//             until the datapath flags termination or MAX_ITER subtractions
//             have been made. Completion is reported by a one-cycle done
//             pulse with an error qualifier.
//  Ports    : clk, rst_i (async, active high), start_i, valid_i
//             busy_o, done_o, err_o             - status towards upstream
//             dp_start_o, alu_mode_o, wren_*_o,
//             *_to_alu_*_o, check_for_termination_o - datapath controls
//  Revision : 1.0  initial release
// ============================================================================
module controller_modulo #(
    parameter int unsigned ALU_LAT  = 1,
    parameter logic [15:0] MAX_ITER = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       valid_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic       dp_start_o,
    output logic [2:0] alu_mode_o,
    output logic       wren_update_Zahlen_o,
    output logic       wren_Zahl1_to_erg_o,
    output logic       wren_term_erg_o,
    output logic       wren_res_to_erg_o,
    output logic       erg_to_alu_a_o,
    output logic       Zahl2_to_alu_b_o,
    output logic       check_for_termination_o
);

    localparam logic [2:0] c_ALU_NOP = 3'd0;
    localparam logic [2:0] c_ALU_SUB = 3'd1;
    localparam logic [2:0] c_ALU_LT  = 3'd2;

    // wcnt must be able to hold the value ALU_LAT
    localparam int unsigned c_WCNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
    localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(ALU_LAT);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_WAIT   = 4'd1,
        S_LOAD   = 4'd2,
        S_INIT   = 4'd3,
        S_CMP    = 4'd4,
        S_CMP_WB = 4'd5,
        S_CHECK  = 4'd6,
        S_SUB    = 4'd7,
        S_SUB_WB = 4'd8,
        S_DONE   = 4'd9
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [15:0]           r_iter;
    logic [c_WCNT_W-1:0]   r_wcnt;
    logic                  r_err;
    logic                  w_wait_done;
    logic                  w_iter_limit;

    // ALU operands have been stable for ALU_LAT+1 cycles
    assign w_wait_done  = (r_wcnt == c_WCNT_LAST);
    assign w_iter_limit = (r_iter == MAX_ITER);

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_iter  <= 16'd0;
            r_wcnt  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_iter <= 16'd0;
                        r_err  <= 1'b0;
                    end
                end
                S_INIT: r_wcnt <= '0;
                S_CMP, S_SUB: begin
                    // counter returns to 0 on the cycle we leave, ready for the next wait
                    if (w_wait_done) r_wcnt <= '0;
                    else             r_wcnt <= r_wcnt + 1'b1;
                end
                S_CHECK: begin
                    r_wcnt <= '0;
                    r_err  <= !valid_i && w_iter_limit;
                end
                S_SUB_WB: begin
                    r_wcnt <= '0;
                    if (r_iter != 16'hFFFF) r_iter <= r_iter + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next                  = r_state;
        busy_o                  = 1'b1;
        done_o                  = 1'b0;
        err_o                   = 1'b0;
        dp_start_o              = 1'b0;
        alu_mode_o              = c_ALU_NOP;
        wren_update_Zahlen_o    = 1'b0;
        wren_Zahl1_to_erg_o     = 1'b0;
        wren_term_erg_o         = 1'b0;
        wren_res_to_erg_o       = 1'b0;
        erg_to_alu_a_o          = 1'b0;
        Zahl2_to_alu_b_o        = 1'b0;
        check_for_termination_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) w_next = S_WAIT;
            end
            S_WAIT: begin
                dp_start_o = 1'b1;
                w_next     = S_LOAD;
            end
            S_LOAD: begin
                wren_update_Zahlen_o = 1'b1;
                w_next               = S_INIT;
            end
            S_INIT: begin
                wren_Zahl1_to_erg_o = 1'b1;
                w_next              = S_CMP;
            end
            S_CMP: begin
                alu_mode_o       = c_ALU_LT;
                erg_to_alu_a_o   = 1'b1;
                Zahl2_to_alu_b_o = 1'b1;
                if (w_wait_done) w_next = S_CMP_WB;
            end
            S_CMP_WB: begin
                alu_mode_o       = c_ALU_LT;
                erg_to_alu_a_o   = 1'b1;
                Zahl2_to_alu_b_o = 1'b1;
                wren_term_erg_o  = 1'b1;
                w_next           = S_CHECK;
            end
            S_CHECK: begin
                check_for_termination_o = 1'b1;
                if (valid_i || w_iter_limit) w_next = S_DONE;
                else                         w_next = S_SUB;
            end
            S_SUB: begin
                alu_mode_o       = c_ALU_SUB;
                erg_to_alu_a_o   = 1'b1;
                Zahl2_to_alu_b_o = 1'b1;
                if (w_wait_done) w_next = S_SUB_WB;
            end
            S_SUB_WB: begin
                alu_mode_o        = c_ALU_SUB;
                erg_to_alu_a_o    = 1'b1;
                Zahl2_to_alu_b_o  = 1'b1;
                wren_res_to_erg_o = 1'b1;
                w_next            = S_CMP;
            end
            S_DONE: begin
                done_o = 1'b1;
                err_o  = r_err;
                w_next = S_IDLE;
            end
            default: begin
                busy_o = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_controller_modulo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_controller_modulo
//  Purpose  : Self-checking bench. Three controller instances (ALU_LAT=1,
//             ALU_LAT=1 with MAX_ITER=4, ALU_LAT=2) each drive a behavioural
//             model of the modulo datapath. Expected result, latency and
//             subtraction count come from plain arithmetic (a % b, a / b).
//  Revision : 1.0  initial release
// ============================================================================
module tb_controller_modulo;

    localparam int          N            = 3;
    localparam int unsigned LAT  [N]     = '{1, 1, 2};
    localparam logic [15:0] MAXI [N]     = '{16'hFFFF, 16'd4, 16'hFFFF};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      start = '0;
    logic [N-1:0]      valid, busy, done, err, dps, wu, wz, wt, wr, sa, sb, chk;
    logic [N-1:0][2:0] mode;
    logic [N-1:0][15:0] zin1 = '0;
    logic [N-1:0][15:0] zin2 = '0;
    logic [N-1:0][15:0] erg_mon;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [15:0] in1, in2, z1r, z2r, erg;
        logic        term;

        controller_modulo #(.ALU_LAT(LAT[g]), .MAX_ITER(MAXI[g])) u_dut (
            .clk                    (clk),
            .rst_i                  (rst),
            .start_i                (start[g]),
            .valid_i                (valid[g]),
            .busy_o                 (busy[g]),
            .done_o                 (done[g]),
            .err_o                  (err[g]),
            .dp_start_o             (dps[g]),
            .alu_mode_o             (mode[g]),
            .wren_update_Zahlen_o   (wu[g]),
            .wren_Zahl1_to_erg_o    (wz[g]),
            .wren_term_erg_o        (wt[g]),
            .wren_res_to_erg_o      (wr[g]),
            .erg_to_alu_a_o         (sa[g]),
            .Zahl2_to_alu_b_o       (sb[g]),
            .check_for_termination_o(chk[g])
        );

        // Behavioural datapath: operands latched on dp_start, then moved to
        // working registers; ergebnis updated by the write-back enables.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                in1 <= '0; in2 <= '0; z1r <= '0; z2r <= '0; erg <= '0; term <= 1'b0;
            end else begin
                if (dps[g]) begin in1 <= zin1[g]; in2 <= zin2[g]; end
                if (wu[g])  begin z1r <= in1; z2r <= in2; end
                if (wz[g])  erg <= z1r;
                if (wt[g])  term <= ($signed(erg) < $signed(z2r));
                if (wr[g])  erg <= erg - z2r;
            end
        end

        assign valid[g]   = term & chk[g];
        assign erg_mon[g] = erg;
    end

    // Invariants on every instance, every cycle
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                check("wren_onehot", ($countones({wu[i], wz[i], wt[i], wr[i]}) <= 1), 1);
                check("mode_nop_when_unselected", ((sa[i] | sb[i]) || mode[i] == 3'd0), 1);
            end
        end
    end

    task automatic run_job(input int idx, input int a, input int b, input bit midstart);
        int          k;
        bit          exp_err;
        int          exp_cyc;
        int          cyc;
        int          pulses;
        bit          seen;
        bit          got_err;
        logic [15:0] got_erg;
        exp_err = (b == 0) || ((a / b) > int'(MAXI[idx]));
        k       = exp_err ? int'(MAXI[idx]) : a / b;
        exp_cyc = 3 + k * (2 * int'(LAT[idx]) + 5) + int'(LAT[idx]) + 4;
        @(negedge clk);
        zin1[idx]  = 16'(a);
        zin2[idx]  = 16'(b);
        start[idx] = 1'b1;
        cyc = 0; pulses = 0; seen = 1'b0; got_err = 1'b0; got_erg = '0;
        while (!seen && cyc < exp_cyc + 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start[idx] = midstart && (cyc == 10);
            if (cyc == 1) check("busy_rise", busy[idx], 1);
            if (wr[idx]) pulses++;
            if (done[idx]) begin
                seen    = 1'b1;
                got_err = err[idx];
                got_erg = erg_mon[idx];
            end
        end
        start[idx] = 1'b0;
        check("done_seen", seen, 1);
        check("done_cycle", cyc, exp_cyc);
        check("err_flag", got_err, exp_err);
        check("sub_pulses", pulses, k);
        if (!exp_err) check("ergebnis", got_erg, a % b);
        @(negedge clk);
        check("busy_fall", busy[idx], 0);
        check("done_single", done[idx], 0);
        if (midstart) begin
            repeat (3) begin
                @(negedge clk);
                check("no_second_job", busy[idx], 0);
            end
        end
    endtask

    initial begin
        int a, b;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check("reset_busy", busy[i], 0);
            check("reset_outputs", {done[i], err[i], dps[i], mode[i], wu[i], wz[i],
                                    wt[i], wr[i], sa[i], sb[i], chk[i]}, 0);
        end
        rst = 1'b0;

        // Asynchronous reset in the middle of the first SUB
        @(negedge clk);
        zin1[0] = 16'd17; zin2[0] = 16'd5; start[0] = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            start[0] = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", busy[0], 0);
        check("async_rst_outputs", {done[0], err[0], dps[0], mode[0], wu[0], wz[0],
                                    wt[0], wr[0], sa[0], sb[0], chk[0]}, 0);
        @(negedge clk);
        rst = 1'b0;
        begin
            bit any_done = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (done[0] || busy[0]) any_done = 1'b1;
            end
            check("abandoned_job_silent", any_done, 0);
        end

        // Directed cases
        run_job(0, 17, 5, 1'b0);
        run_job(0, 3, 7, 1'b0);
        run_job(0, 20, 4, 1'b0);
        run_job(0, 0, 9, 1'b0);
        run_job(1, 5, 0, 1'b1);
        run_job(1, 12, 3, 1'b0);
        run_job(2, 10, 3, 1'b0);

        // Randomised jobs
        for (int n = 0; n < 12; n++) begin
            a = $urandom_range(0, 400);
            b = $urandom_range(1, 400);
            run_job(0, a, b, 1'b0);
        end
        for (int n = 0; n < 6; n++) begin
            a = $urandom_range(0, 200);
            b = $urandom_range(1, 60);
            run_job(1, a, b, 1'b0);
            a = $urandom_range(0, 300);
            b = $urandom_range(1, 300);
            run_job(2, a, b, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
